// File: rtl/reaction_game_ctrl.sv
// Reaction-time game controller.
// Round flow: IDLE -> WAIT (pseudo-random delay) -> GO (time the response) -> RESULT.
// A millisecond prescaler, a free-running 16-bit LFSR and a lowest-time register
// back the FSM. Every output comes straight from a register.
module reaction_game_ctrl #(
  parameter int MS_DIV       = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int MAX_MS       = 9999
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        start_btn,
  input  logic        react_btn,
  output logic [1:0]  state,
  output logic        new_hs,
  output logic        false_start,
  output logic        go_led,
  output logic [13:0] reaction_ms,
  output logic [13:0] highscore_ms
);

  localparam int CW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [CW-1:0] MS_LAST   = CW'(MS_DIV - 1);
  localparam logic [13:0]   MAX_VAL   = 14'(MAX_MS);
  localparam logic [15:0]   MIN_DELAY = 16'(MIN_DELAY_MS);
  localparam logic [15:0]   LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_GO     = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   ms_cnt_reg, ms_cnt_next;
  logic            ms_tick;
  logic [15:0]     lfsr_reg;
  logic            lfsr_fb;
  logic [15:0]     delay_reg, delay_next;
  logic [15:0]     elapsed_reg, elapsed_next;
  logic [13:0]     reaction_reg, reaction_next;
  logic [13:0]     hs_reg, hs_next;
  logic            new_hs_reg, new_hs_next;
  logic            fs_reg, fs_next;
  logic            go_led_reg, go_led_next;
  logic            changing;

  assign ms_tick  = (ms_cnt_reg == MS_LAST);
  assign lfsr_fb  = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
  assign changing = (state_next != state_reg);

  // LFSR runs every cycle, including IDLE, so the start moment picks the delay.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
    end
  end

  // State register.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; react always wins over a coincident tick or timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_btn) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (react_btn) begin
          state_next = S_RESULT;
        end else if (ms_tick && ((elapsed_reg + 16'd1) >= delay_reg)) begin
          state_next = S_GO;
        end
      end
      S_GO: begin
        if (react_btn) begin
          state_next = S_RESULT;
        end else if (reaction_reg >= MAX_VAL) begin
          state_next = S_RESULT;
        end else if (ms_tick && ((reaction_reg + 14'd1) >= MAX_VAL)) begin
          state_next = S_RESULT;
        end
      end
      S_RESULT: begin
        if (start_btn) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath/output next values computed alongside the state decision.
  always_comb begin
    ms_cnt_next   = (changing || ms_tick) ? '0 : ms_cnt_reg + 1'b1;
    elapsed_next  = elapsed_reg;
    delay_next    = delay_reg;
    reaction_next = reaction_reg;
    hs_next       = hs_reg;
    new_hs_next   = new_hs_reg;
    fs_next       = fs_reg;
    go_led_next   = (state_next == S_GO);

    if (changing) begin
      elapsed_next = '0;
    end else if (state_reg == S_WAIT && ms_tick) begin
      elapsed_next = elapsed_reg + 16'd1;
    end

    case (state_reg)
      S_IDLE: begin
        if (start_btn) begin
          delay_next  = MIN_DELAY + {5'd0, lfsr_reg[10:0]};
          new_hs_next = 1'b0;
          fs_next     = 1'b0;
        end
      end
      S_WAIT: begin
        if (react_btn) begin
          fs_next     = 1'b1;
          new_hs_next = 1'b0;
        end else if (state_next == S_GO) begin
          reaction_next = '0;
        end
      end
      S_GO: begin
        if (react_btn) begin
          // Reaction time is frozen; a strictly lower time beats the record.
          if (reaction_reg < hs_reg) begin
            hs_next     = reaction_reg;
            new_hs_next = 1'b1;
          end else begin
            new_hs_next = 1'b0;
          end
        end else if (reaction_reg >= MAX_VAL) begin
          reaction_next = MAX_VAL;
          new_hs_next   = 1'b0;
        end else if (ms_tick) begin
          reaction_next = reaction_reg + 14'd1;
          if (state_next == S_RESULT) new_hs_next = 1'b0;
        end
      end
      S_RESULT: begin
        if (start_btn) begin
          new_hs_next = 1'b0;
          fs_next     = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      ms_cnt_reg   <= '0;
      elapsed_reg  <= '0;
      delay_reg    <= '0;
      reaction_reg <= '0;
      hs_reg       <= MAX_VAL;
      new_hs_reg   <= 1'b0;
      fs_reg       <= 1'b0;
      go_led_reg   <= 1'b0;
    end else begin
      ms_cnt_reg   <= ms_cnt_next;
      elapsed_reg  <= elapsed_next;
      delay_reg    <= delay_next;
      reaction_reg <= reaction_next;
      hs_reg       <= hs_next;
      new_hs_reg   <= new_hs_next;
      fs_reg       <= fs_next;
      go_led_reg   <= go_led_next;
    end
  end

  assign state        = state_reg;
  assign new_hs       = new_hs_reg;
  assign false_start  = fs_reg;
  assign go_led       = go_led_reg;
  assign reaction_ms  = reaction_reg;
  assign highscore_ms = hs_reg;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed bench for reaction_game_ctrl with MS_DIV=4, MIN_DELAY_MS=2, MAX_MS=20.
module tb_reaction_game_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_btn;
  logic        react_btn;
  logic [1:0]  state;
  logic        new_hs;
  logic        false_start;
  logic        go_led;
  logic [13:0] reaction_ms;
  logic [13:0] highscore_ms;

  int total = 0;
  int bad   = 0;
  int exp_delay;
  logic [15:0] lfsr_m;

  reaction_game_ctrl #(.MS_DIV(4), .MIN_DELAY_MS(2), .MAX_MS(20)) dut (
    .iCLK(clk), .iRST(rst), .start_btn(start_btn), .react_btn(react_btn),
    .state(state), .new_hs(new_hs), .false_start(false_start), .go_led(go_led),
    .reaction_ms(reaction_ms), .highscore_ms(highscore_ms)
  );

  always #5 clk = ~clk;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1 on reset.
  always @(posedge clk) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock edge; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
  endtask

  task automatic pulse_react();
    react_btn = 1'b1;
    step();
    react_btn = 1'b0;
  endtask

  task automatic do_start();
    exp_delay = 2 + int'(lfsr_m[10:0]);
    pulse_start();
    chk("wait_state", 32'(state), 32'd1);
  endtask

  // Count edges from WAIT entry until GO; a start pulse mid-WAIT must be ignored.
  task automatic wait_go(input bit inject_start);
    int n = 0;
    while (state !== 2'd2 && n < 20000) begin
      start_btn = (inject_start && n == 2);
      step();
      n++;
    end
    start_btn = 1'b0;
    chk("go_state", 32'(state), 32'd2);
    chk("go_latency", 32'(n), 32'(4 * exp_delay));
    chk("go_led_on", 32'(go_led), 32'd1);
    chk("go_reaction_zero", 32'(reaction_ms), 32'd0);
    $display("round: delay_ms=%0d go after %0d cycles", exp_delay, n);
  endtask

  initial begin
    rst = 1'b1; start_btn = 1'b0; react_btn = 1'b0;
    @(negedge clk);
    step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_hs", 32'(highscore_ms), 32'd20);
    chk("rst_reaction", 32'(reaction_ms), 32'd0);
    chk("rst_flags", {29'd0, new_hs, false_start, go_led}, 32'd0);
    rst = 1'b0;

    // react in IDLE ignored
    pulse_react();
    chk("idle_react_ignored", 32'(state), 32'd0);

    // Round 1: timeout after 20 ticks
    do_start();
    chk("wait_go_led_off", 32'(go_led), 32'd0);
    wait_go(1'b1);
    repeat (79) step();
    chk("pre_timeout_state", 32'(state), 32'd2);
    chk("pre_timeout_reaction", 32'(reaction_ms), 32'd19);
    step();
    chk("timeout_state", 32'(state), 32'd3);
    chk("timeout_reaction", 32'(reaction_ms), 32'd20);
    chk("timeout_new_hs", 32'(new_hs), 32'd0);
    chk("timeout_hs", 32'(highscore_ms), 32'd20);
    chk("timeout_go_led", 32'(go_led), 32'd0);
    $display("timeout: reaction=%0d hs=%0d", reaction_ms, highscore_ms);
    pulse_react();
    chk("result_react_ignored", 32'(state), 32'd3);
    chk("result_reaction_held", 32'(reaction_ms), 32'd20);
    pulse_start();
    chk("result_to_idle", 32'(state), 32'd0);

    // Round 2: react after 7 ticks -> new high score
    do_start();
    wait_go(1'b0);
    repeat (28) step();
    pulse_react();
    chk("r7_state", 32'(state), 32'd3);
    chk("r7_reaction", 32'(reaction_ms), 32'd7);
    chk("r7_hs", 32'(highscore_ms), 32'd7);
    chk("r7_new_hs", 32'(new_hs), 32'd1);
    $display("react7: reaction=%0d hs=%0d new_hs=%0d", reaction_ms, highscore_ms, new_hs);
    pulse_start();
    chk("idle_new_hs_clear", 32'(new_hs), 32'd0);

    // Round 3: 9 ticks, slower than record
    do_start();
    wait_go(1'b0);
    repeat (36) step();
    pulse_react();
    chk("r9_reaction", 32'(reaction_ms), 32'd9);
    chk("r9_hs", 32'(highscore_ms), 32'd7);
    chk("r9_new_hs", 32'(new_hs), 32'd0);
    $display("react9: reaction=%0d hs=%0d new_hs=%0d", reaction_ms, highscore_ms, new_hs);
    pulse_start();

    // Round 4: equal time is not a new record
    do_start();
    wait_go(1'b0);
    repeat (28) step();
    pulse_react();
    chk("eq_reaction", 32'(reaction_ms), 32'd7);
    chk("eq_new_hs", 32'(new_hs), 32'd0);
    chk("eq_hs", 32'(highscore_ms), 32'd7);
    pulse_start();

    // Round 5: false start
    do_start();
    repeat (3) step();
    pulse_react();
    chk("fs_state", 32'(state), 32'd3);
    chk("fs_flag", 32'(false_start), 32'd1);
    chk("fs_new_hs", 32'(new_hs), 32'd0);
    chk("fs_hs", 32'(highscore_ms), 32'd7);
    chk("fs_reaction", 32'(reaction_ms), 32'd7);
    $display("false start: state=%0d false_start=%0d", state, false_start);
    pulse_start();
    chk("fs_idle", 32'(state), 32'd0);
    chk("fs_clear", 32'(false_start), 32'd0);

    // Round 6: react on the 5th tick edge -> 4
    do_start();
    wait_go(1'b0);
    repeat (19) step();
    pulse_react();
    chk("coinc_reaction", 32'(reaction_ms), 32'd4);
    chk("coinc_hs", 32'(highscore_ms), 32'd4);
    chk("coinc_new_hs", 32'(new_hs), 32'd1);
    $display("coincident: reaction=%0d hs=%0d", reaction_ms, highscore_ms);
    pulse_start();

    // Round 7: reset mid-GO dominates a simultaneous react
    do_start();
    wait_go(1'b0);
    repeat (10) step();
    rst = 1'b1; react_btn = 1'b1;
    step();
    rst = 1'b0; react_btn = 1'b0;
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_go_led", 32'(go_led), 32'd0);
    chk("midrst_hs", 32'(highscore_ms), 32'd20);
    chk("midrst_reaction", 32'(reaction_ms), 32'd0);
    chk("midrst_new_hs", 32'(new_hs), 32'd0);
    $display("mid-GO reset: state=%0d hs=%0d", state, highscore_ms);

    // After reset the LFSR restarts from its seed
    do_start();
    wait_go(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
